// File: rtl/mob_pkg.sv
// Shared types for the matrix operand buffer: controller states and load-target encodings.
package mob_pkg;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      READY  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } mob_state_t;

   localparam logic SEL_W = 1'b0;
   localparam logic SEL_X = 1'b1;

endpackage

// File: rtl/mob_load_counter.sv
// Saturating fill counter for one operand matrix; full_nxt looks one edge ahead so the
// controller can leave LOAD on the same edge as the final write.
module mob_load_counter #(
   parameter int MAX   = 9,
   parameter int CNT_W = $clog2(MAX + 1)
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             flush,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             full_nxt
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (inc && !full) begin
         count <= count + 1'b1;
      end
   end

   assign full     = (count == CNT_MAX);
   assign full_nxt = full || (inc && (count == CNT_MAX - 1'b1));

endmodule

// File: rtl/matrix_operand_buffer.sv
// N x N operand store: serial load of W and X, then N valid/ready outer-product beats.
// Define MOB_OVF_FLAG_EN to enable the sticky ovf_err overflow flag.
//
// state  | meaning
// LOAD   | accepting load beats until both matrices hold N*N elements
// READY  | both matrices full, start high, waiting for run
// STREAM | presenting beat k (column k of W, row k of X) until handshake
// DONE   | pass complete; run replays, flush returns to LOAD
module matrix_operand_buffer
   import mob_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int N      = 3
) (
   input  logic                  clk,
   input  logic                  clear_n,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic                  in_sel,
   input  logic [DATA_W-1:0]     data_in,
   output logic                  in_ready,
   output logic                  start,
   input  logic                  run,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [$clog2(N)-1:0]  out_idx,
   output logic                  out_last,
   output logic [N*DATA_W-1:0]   data_outw,
   output logic [N*DATA_W-1:0]   data_outx,
   output logic                  done,
   output logic                  ovf_err
);

   localparam int CNT_W  = $clog2(N*N + 1);
   localparam int IDX_W  = $clog2(N);
   localparam int ADDR_W = $clog2(N*N);
   localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);

   mob_state_t state;

   logic [DATA_W-1:0] w_mem [N*N];
   logic [DATA_W-1:0] x_mem [N*N];

   logic [CNT_W-1:0] w_cnt, x_cnt;
   logic w_full, x_full, w_full_nxt, x_full_nxt;
   logic accept, w_inc, x_inc;

   assign in_ready = (state == LOAD) && ((in_sel == SEL_X) ? !x_full : !w_full);
   // flush drops any load beat presented in the same cycle
   assign accept   = in_valid && in_ready && !flush;
   assign w_inc    = accept && (in_sel == SEL_W);
   assign x_inc    = accept && (in_sel == SEL_X);

   mob_load_counter #(.MAX(N*N), .CNT_W(CNT_W)) u_cnt_w (
      .clk      (clk),
      .clear_n  (clear_n),
      .flush    (flush),
      .inc      (w_inc),
      .count    (w_cnt),
      .full     (w_full),
      .full_nxt (w_full_nxt)
   );

   mob_load_counter #(.MAX(N*N), .CNT_W(CNT_W)) u_cnt_x (
      .clk      (clk),
      .clear_n  (clear_n),
      .flush    (flush),
      .inc      (x_inc),
      .count    (x_cnt),
      .full     (x_full),
      .full_nxt (x_full_nxt)
   );

   always_ff @(posedge clk) begin
      if (w_inc) w_mem[ADDR_W'(w_cnt)] <= data_in;
      if (x_inc) x_mem[ADDR_W'(x_cnt)] <= data_in;
   end

   logic [IDX_W-1:0]    nxt_idx;
   logic [N*DATA_W-1:0] nxt_w, nxt_x;

   // Operands for the beat that will be presented after the next edge.
   always_comb begin
      nxt_idx = '0;
      if (state == STREAM && out_idx != K_LAST) nxt_idx = out_idx + 1'b1;
      nxt_w = '0;
      nxt_x = '0;
      for (int i = 0; i < N; i++) begin
         nxt_w[i*DATA_W +: DATA_W] = w_mem[ADDR_W'(i*N + int'(nxt_idx))];
         nxt_x[i*DATA_W +: DATA_W] = x_mem[ADDR_W'(int'(nxt_idx)*N + i)];
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state     <= LOAD;
         start     <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         data_outw <= '0;
         data_outx <= '0;
      end else if (flush) begin
         state     <= LOAD;
         start     <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         data_outw <= '0;
         data_outx <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (w_full_nxt && x_full_nxt) begin
                  state <= READY;
                  start <= 1'b1;
               end
            end
            READY, DONE: begin
               if (run) begin
                  state     <= STREAM;
                  start     <= 1'b0;
                  done      <= 1'b0;
                  out_valid <= 1'b1;
                  out_idx   <= '0;
                  out_last  <= 1'b0;
                  data_outw <= nxt_w;
                  data_outx <= nxt_x;
               end
            end
            STREAM: begin
               if (out_ready) begin
                  if (out_idx == K_LAST) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     out_valid <= 1'b0;
                     out_idx   <= '0;
                     out_last  <= 1'b0;
                     data_outw <= '0;
                     data_outx <= '0;
                  end else begin
                     out_idx   <= nxt_idx;
                     out_last  <= (nxt_idx == K_LAST);
                     data_outw <= nxt_w;
                     data_outx <= nxt_x;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

`ifdef MOB_OVF_FLAG_EN
   // in_ready is low both for a full target and for any state other than LOAD
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         ovf_err <= 1'b0;
      end else if (flush) begin
         ovf_err <= 1'b0;
      end else if (in_valid && !in_ready) begin
         ovf_err <= 1'b1;
      end
   end
`else
   assign ovf_err = 1'b0;
`endif

endmodule
